// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: state encodings,
// default timing/width and the per-state strobe decode.
package rtc_bus_sequencer_pkg;

    localparam int T_PH_DEFAULT = 4;
    localparam int AW_DEFAULT   = 8;
    localparam int CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR_SETUP  = 3'd1,
        ST_ADDR_STROBE = 3'd2,
        ST_ADDR_HOLD   = 3'd3,
        ST_DATA_SETUP  = 3'd4,
        ST_DATA_STROBE = 3'd5,
        ST_DATA_HOLD   = 3'd6,
        ST_DONE        = 3'd7
    } state_e;

    typedef struct packed {
        logic a_d;
        logic cs;
        logic rd;
        logic wr;
        logic oe;
    } bus_ctrl_t;

    function automatic logic is_bus_state(input state_e st);
        logic r;
        case (st)
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD,
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic state_e next_bus_state(input state_e st);
        state_e n;
        case (st)
            ST_ADDR_SETUP:  n = ST_ADDR_STROBE;
            ST_ADDR_STROBE: n = ST_ADDR_HOLD;
            ST_ADDR_HOLD:   n = ST_DATA_SETUP;
            ST_DATA_SETUP:  n = ST_DATA_STROBE;
            ST_DATA_STROBE: n = ST_DATA_HOLD;
            ST_DATA_HOLD:   n = ST_DONE;
            default:        n = ST_IDLE;
        endcase
        return n;
    endfunction

    // The address is always written to the RTC, so ADDR_STROBE pulses wr even on reads.
    function automatic bus_ctrl_t ctrl_for(input state_e st, input logic is_read);
        bus_ctrl_t c;
        c.a_d = 1'b1;
        c.cs  = 1'b1;
        c.rd  = 1'b1;
        c.wr  = 1'b1;
        c.oe  = 1'b0;
        case (st)
            ST_ADDR_SETUP, ST_ADDR_HOLD: begin
                c.a_d = 1'b0;
                c.oe  = 1'b1;
            end
            ST_ADDR_STROBE: begin
                c.a_d = 1'b0;
                c.oe  = 1'b1;
                c.cs  = 1'b0;
                c.wr  = 1'b0;
            end
            ST_DATA_SETUP, ST_DATA_HOLD: begin
                c.oe = ~is_read;
            end
            ST_DATA_STROBE: begin
                c.cs = 1'b0;
                if (is_read) begin
                    c.rd = 1'b0;
                end else begin
                    c.wr = 1'b0;
                    c.oe = 1'b1;
                end
            end
            default: begin
                c.a_d = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_bus_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rtc_bus_rr_arbiter
    import rtc_bus_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic       o_valid,
    output logic       o_id
);

    logic r_last;

    // Winner select: on a tie the requester not granted last wins.
    always_comb begin
        o_valid = i_req[0] | i_req[1];
        if (i_req[0] && i_req[1]) begin
            o_id = ~r_last;
        end else if (i_req[1]) begin
            o_id = 1'b1;
        end else begin
            o_id = 1'b0;
        end
    end

    // Pointer update; reset marks requester 1 as last so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_grant_en && o_valid) begin
            r_last <= o_id;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences address/data phases on a multiplexed RTC bus for two requesters.
// All bus outputs are registered, decoded from the next state so they align with it.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int T_PH = T_PH_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] wdata0,
    input  logic [AW-1:0] wdata1,
    input  logic [AW-1:0] bus_in,
    output logic [AW-1:0] bus_out,
    output logic          bus_oe,
    output logic          a_d,
    output logic          cs,
    output logic          rd,
    output logic          wr,
    output logic          done0,
    output logic          done1,
    output logic [AW-1:0] rdata,
    output logic          busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(T_PH - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rw;
    logic             r_gid;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_wdata;

    logic             w_gnt_valid;
    logic             w_gnt_id;
    logic             w_grant_en;
    logic             w_grant_take;
    logic             w_phase_end;
    logic             w_nxt_rw;
    logic [AW-1:0]    w_nxt_addr;
    logic [AW-1:0]    w_nxt_wdata;
    logic [AW-1:0]    w_nxt_bus;
    bus_ctrl_t        w_nxt_ctrl;

    bus_ctrl_t        r_ctrl;
    logic [AW-1:0]    r_bus_out;
    logic             r_done0;
    logic             r_done1;
    logic [AW-1:0]    r_rdata;
    logic             r_busy;

    assign w_grant_en   = (r_state == ST_IDLE);
    assign w_grant_take = w_grant_en & w_gnt_valid;
    assign w_phase_end  = (r_cnt == LAST_CNT);

    rtc_bus_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_req      ({req1, req0}),
        .i_grant_en (w_grant_en),
        .o_valid    (w_gnt_valid),
        .o_id       (w_gnt_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: bus states advance when the phase counter reaches T_PH-1.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_next_state = ST_ADDR_SETUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD,
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
                if (w_phase_end) begin
                    w_next_state = next_bus_state(r_state);
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Phase counter restarts whenever the state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_next_state != r_state) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (is_bus_state(r_state)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    // Transaction fields as they will be after this edge (winner's inputs on a grant).
    always_comb begin
        w_nxt_rw    = r_rw;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        if (w_grant_take) begin
            w_nxt_rw    = w_gnt_id ? rw1    : rw0;
            w_nxt_addr  = w_gnt_id ? addr1  : addr0;
            w_nxt_wdata = w_gnt_id ? wdata1 : wdata0;
        end else begin
            w_nxt_rw    = r_rw;
        end
    end

    // Latch the winner's fields; requester inputs are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw    <= 1'b0;
            r_gid   <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_wdata <= {AW{1'b0}};
        end else if (w_grant_take) begin
            r_rw    <= w_nxt_rw;
            r_gid   <= w_gnt_id;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
        end else begin
            r_rw    <= r_rw;
        end
    end

    // Drive value for the next state.
    always_comb begin
        w_nxt_ctrl = ctrl_for(w_next_state, w_nxt_rw);
        case (w_next_state)
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: w_nxt_bus = w_nxt_addr;
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
                if (w_nxt_rw) begin
                    w_nxt_bus = {AW{1'b0}};
                end else begin
                    w_nxt_bus = w_nxt_wdata;
                end
            end
            default: w_nxt_bus = {AW{1'b0}};
        endcase
    end

    // Registered bus outputs, done pulses and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= ctrl_for(ST_IDLE, 1'b0);
            r_bus_out <= {AW{1'b0}};
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ctrl    <= w_nxt_ctrl;
            r_bus_out <= w_nxt_bus;
            r_done0   <= (w_next_state == ST_DONE) && !r_gid;
            r_done1   <= (w_next_state == ST_DONE) && r_gid;
            r_busy    <= (w_next_state != ST_IDLE);
        end
    end

    // Read data is sampled on the final cycle of the read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= {AW{1'b0}};
        end else if ((r_state == ST_DATA_STROBE) && w_phase_end && r_rw) begin
            r_rdata <= bus_in;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign bus_out = r_bus_out;
    assign bus_oe  = r_ctrl.oe;
    assign a_d     = r_ctrl.a_d;
    assign cs      = r_ctrl.cs;
    assign rd      = r_ctrl.rd;
    assign wr      = r_ctrl.wr;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign rdata   = r_rdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench: two sequencers (T_PH=4 and T_PH=1) share stimulus; a cycle-index
// model of the bus waveform predicts every output of the instance under test.
module tb_rtc_bus_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, rw0, rw1;
    logic [AW-1:0] addr0, addr1, wdata0, wdata1, bus_in;

    logic [AW-1:0] bo4, rdat4, bo1, rdat1;
    logic          oe4, ad4, cs4, rdn4, wrn4, d04, d14, busy4;
    logic          oe1, ad1, cs1, rdn1, wrn1, d01, d11, busy1;

    int            n_tests   = 0;
    int            n_fail    = 0;
    int            cur_t     = 4;
    int            last_gnt  = 1;
    logic [AW-1:0] exp_rdata = '0;

    logic [AW+7:0] obs;
    logic [AW-1:0] obs_rdata;

    always #5 clk = ~clk;

    rtc_bus_sequencer #(.T_PH(4), .AW(AW)) dut4 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .bus_in(bus_in),
        .bus_out(bo4), .bus_oe(oe4), .a_d(ad4), .cs(cs4), .rd(rdn4), .wr(wrn4),
        .done0(d04), .done1(d14), .rdata(rdat4), .busy(busy4)
    );

    rtc_bus_sequencer #(.T_PH(1), .AW(AW)) dut1 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .bus_in(bus_in),
        .bus_out(bo1), .bus_oe(oe1), .a_d(ad1), .cs(cs1), .rd(rdn1), .wr(wrn1),
        .done0(d01), .done1(d11), .rdata(rdat1), .busy(busy1)
    );

    always_comb begin
        if (cur_t == 1) begin
            obs       = {ad1, cs1, rdn1, wrn1, oe1, busy1, d01, d11, bo1};
            obs_rdata = rdat1;
        end else begin
            obs       = {ad4, cs4, rdn4, wrn4, oe4, busy4, d04, d14, bo4};
            obs_rdata = rdat4;
        end
    end

    // Expected outputs in cycle k of a transaction (k=0 is the sampling IDLE cycle).
    function automatic logic [AW+7:0] exp_vec(input int k, input int t, input logic is_rd,
                                              input logic [AW-1:0] a, input logic [AW-1:0] d,
                                              input int who);
        int ph;
        logic ad, csn, rdn, wrn, oe, bsy, dn0, dn1;
        logic [AW-1:0] bo;
        {ad, csn, rdn, wrn, oe, bsy, dn0, dn1} = 8'b1111_0000;
        bo = '0;
        if (k >= 1 && k <= 6 * t) begin
            ph  = (k - 1) / t;
            bsy = 1'b1;
            ad  = (ph >= 3);
            csn = !(ph == 1 || ph == 4);
            wrn = !(ph == 1 || (ph == 4 && !is_rd));
            rdn = !(ph == 4 && is_rd);
            oe  = (ph < 3) || !is_rd;
            bo  = (ph < 3) ? a : (is_rd ? '0 : d);
        end else if (k == 6 * t + 1) begin
            bsy = 1'b1;
            dn0 = (who == 0);
            dn1 = (who == 1);
        end
        return {ad, csn, rdn, wrn, oe, bsy, dn0, dn1, bo};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_rdata = '0;
        last_gnt  = 1;
    endtask

    // Runs one transaction starting at a negedge in IDLE; requester fields are set by the caller.
    task automatic do_txn(input string tag, input logic [1:0] mask, input logic keep,
                          input logic scramble, input logic [AW-1:0] rv);
        int w;
        logic is_rd;
        logic [AW-1:0] a, d, e;
        logic [AW+7:0] ev;
        w        = (mask == 2'b11) ? 1 - last_gnt : (mask[1] ? 1 : 0);
        last_gnt = w;
        is_rd    = (w == 1) ? rw1 : rw0;
        a        = (w == 1) ? addr1 : addr0;
        d        = (w == 1) ? wdata1 : wdata0;
        req0     = mask[0];
        req1     = mask[1];
        bus_in   = AW'($urandom);
        for (int k = 1; k <= 6 * cur_t + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5 * cur_t + 1 && is_rd) exp_rdata = rv;
            ev = exp_vec(k, cur_t, is_rd, a, d, w);
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL %s cycle %0d bus: got %h expected %h", tag, k, obs, ev);
            end
            e = exp_rdata;
            n_tests++;
            if (obs_rdata !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d rdata: got %h expected %h", tag, k, obs_rdata, e);
            end
            bus_in = (k == 5 * cur_t) ? rv : AW'($urandom);
            if (scramble && k <= 6 * cur_t) begin
                addr0  = AW'($urandom);
                addr1  = AW'($urandom);
                wdata0 = AW'($urandom);
                wdata1 = AW'($urandom);
                rw0    = 1'($urandom);
                rw1    = 1'($urandom);
                if (w == 0) req1 = 1'($urandom);
                else        req0 = 1'($urandom);
            end
            if (k == 6 * cur_t + 1) begin
                if (w == 0) begin req0 = keep;    req1 = mask[1]; end
                else        begin req0 = mask[0]; req1 = keep;    end
            end
        end
        @(posedge clk);
        @(negedge clk);
        ev = exp_vec(0, cur_t, 1'b0, '0, '0, -1);
        n_tests++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL %s idle-after bus: got %h expected %h", tag, obs, ev);
        end
    endtask

    task automatic test_reset();
        logic [AW+7:0] ev;
        apply_reset();
        ev = exp_vec(0, 4, 1'b0, '0, '0, -1);
        n_tests++;
        if ({ad4, cs4, rdn4, wrn4, oe4, busy4, d04, d14, bo4} !== ev || rdat4 !== '0) begin
            n_fail++;
            $display("FAIL reset_t4: got %h/%h expected %h/00", {ad4, cs4, rdn4, wrn4, oe4, busy4, d04, d14, bo4}, rdat4, ev);
        end
        n_tests++;
        if ({ad1, cs1, rdn1, wrn1, oe1, busy1, d01, d11, bo1} !== ev || rdat1 !== '0) begin
            n_fail++;
            $display("FAIL reset_t1: got %h/%h expected %h/00", {ad1, cs1, rdn1, wrn1, oe1, busy1, d01, d11, bo1}, rdat1, ev);
        end
    endtask

    task automatic test_write();
        cur_t = 4;
        rw0 = 1'b0; addr0 = 8'h21; wdata0 = 8'h45;
        do_txn("write_fixed", 2'b01, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_read();
        cur_t = 4;
        rw1 = 1'b1; addr1 = 8'h24; wdata1 = 8'hA7;
        do_txn("read_fixed", 2'b10, 1'b0, 1'b0, 8'h59);
    endtask

    task automatic test_random();
        cur_t = 4;
        for (int i = 0; i < 8; i++) begin
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = AW'($urandom); wdata1 = AW'($urandom);
            do_txn("random", 2'($urandom_range(3, 1)), 1'b0, 1'b1, AW'($urandom));
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_round_robin();
        cur_t = 4;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = AW'($urandom); wdata1 = AW'($urandom);
            do_txn("round_robin", 2'b11, 1'b1, 1'b0, AW'($urandom));
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [AW+7:0] ev;
        cur_t = 4;
        rw0 = 1'b1; addr0 = AW'($urandom);
        do_txn("pre_read", 2'b01, 1'b0, 1'b0, 8'h80 | AW'($urandom));
        rw0 = 1'b0; addr0 = AW'($urandom); wdata0 = AW'($urandom);
        req0 = 1'b1; req1 = 1'b0;
        repeat (18) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ev = exp_vec(0, 4, 1'b0, '0, '0, -1);
        n_tests++;
        if (obs !== ev || obs_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h/%h expected %h/00", obs, obs_rdata, ev);
        end
        reset = 1'b0; req0 = 1'b0;
        exp_rdata = '0; last_gnt = 1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL reset_mid_after cycle %0d: got %h expected %h", k, obs, ev);
            end
        end
    endtask

    task automatic test_tph1_back_to_back();
        apply_reset();
        cur_t = 1;
        for (int i = 0; i < 4; i++) begin
            rw0 = 1'b1; addr0 = AW'($urandom);
            do_txn("tph1_b2b", 2'b01, (i < 3) ? 1'b1 : 1'b0, 1'b0, AW'($urandom));
        end
        req0 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; bus_in = '0;
        test_reset();
        test_write();
        test_read();
        test_random();
        test_round_robin();
        test_reset_mid();
        test_tph1_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
